// File: rtl/imem_loader.sv
// Instruction memory loader: packs a byte stream into little-endian 32-bit words,
// writes them from word address 0 upward and holds the CPU in reset while loading.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W:0]   i_num_words,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte_data,
  output logic              o_byte_ready,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [31:0]       o_mem_data,
  output logic              o_mem_wren,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W+1)'(1);

  state_t              r_state;
  logic [ADDR_W:0]     r_num_words;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_byte_idx;
  logic [23:0]         r_word;
  logic [ADDR_W-1:0]   r_mem_address;
  logic [31:0]         r_mem_data;
  logic                r_byte_ready;
  logic                r_mem_wren;
  logic                r_cpu_hold;
  logic                r_busy;
  logic                r_done;
  logic                r_error;

  state_t              w_state_next;
  logic [ADDR_W:0]     w_num_words_next;
  logic [ADDR_W-1:0]   w_addr_next;
  logic [1:0]          w_byte_idx_next;
  logic [23:0]         w_word_next;
  logic [ADDR_W-1:0]   w_mem_address_next;
  logic [31:0]         w_mem_data_next;
  logic                w_error_next;
  logic [ADDR_W:0]     w_addr_inc;
  logic                w_start_ok;
  logic                w_accept;

  assign w_addr_inc = {1'b0, r_addr} + LP_ONE;
  assign w_start_ok = (i_num_words != '0) && (i_num_words <= LP_DEPTH);
  assign w_accept   = i_byte_valid && r_byte_ready;

  always_comb begin
    w_state_next       = r_state;
    w_num_words_next   = r_num_words;
    w_addr_next        = r_addr;
    w_byte_idx_next    = r_byte_idx;
    w_word_next        = r_word;
    w_mem_address_next = r_mem_address;
    w_mem_data_next    = r_mem_data;
    w_error_next       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_start_ok) begin
            w_num_words_next = i_num_words;
            w_addr_next      = '0;
            w_byte_idx_next  = '0;
            w_state_next     = S_LOAD;
          end else begin
            w_error_next = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          w_byte_idx_next = r_byte_idx + 2'd1;
          case (r_byte_idx)
            2'd0: w_word_next[7:0]   = i_byte_data;
            2'd1: w_word_next[15:8]  = i_byte_data;
            2'd2: w_word_next[23:16] = i_byte_data;
            default: begin
              // Fourth byte goes straight into the output word for the write cycle
              w_mem_data_next    = {i_byte_data, r_word};
              w_mem_address_next = r_addr;
              w_state_next       = S_WRITE;
            end
          endcase
        end
      end
      S_WRITE: begin
        if (w_addr_inc == r_num_words) begin
          w_state_next = S_DONE;
        end else begin
          w_addr_next     = w_addr_inc[ADDR_W-1:0];
          w_byte_idx_next = '0;
          w_state_next    = S_LOAD;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Status outputs are registered copies of what the next state implies
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_num_words   <= '0;
      r_addr        <= '0;
      r_byte_idx    <= '0;
      r_word        <= '0;
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_byte_ready  <= 1'b0;
      r_mem_wren    <= 1'b0;
      r_cpu_hold    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_num_words   <= w_num_words_next;
      r_addr        <= w_addr_next;
      r_byte_idx    <= w_byte_idx_next;
      r_word        <= w_word_next;
      r_mem_address <= w_mem_address_next;
      r_mem_data    <= w_mem_data_next;
      r_byte_ready  <= (w_state_next == S_LOAD);
      r_mem_wren    <= (w_state_next == S_WRITE);
      r_cpu_hold    <= (w_state_next == S_LOAD) || (w_state_next == S_WRITE);
      r_busy        <= (w_state_next == S_LOAD) || (w_state_next == S_WRITE);
      r_done        <= (w_state_next == S_DONE);
      r_error       <= w_error_next;
    end
  end

  assign o_byte_ready  = r_byte_ready;
  assign o_mem_address = r_mem_address;
  assign o_mem_data    = r_mem_data;
  assign o_mem_wren    = r_mem_wren;
  assign o_cpu_hold    = r_cpu_hold;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_error       = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random programs are expanded into expected word writes
// and compared against every mem_wren the loader produces.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_start = 1'b0;
  logic [ADDR_W:0]   i_num_words = '0;
  logic              i_byte_valid = 1'b0;
  logic [7:0]        i_byte_data = '0;
  logic              o_byte_ready;
  logic [ADDR_W-1:0] o_mem_address;
  logic [31:0]       o_mem_data;
  logic              o_mem_wren;
  logic              o_cpu_hold;
  logic              o_busy;
  logic              o_done;
  logic              o_error;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_num_words(i_num_words),
    .i_byte_valid(i_byte_valid), .i_byte_data(i_byte_data), .o_byte_ready(o_byte_ready),
    .o_mem_address(o_mem_address), .o_mem_data(o_mem_data), .o_mem_wren(o_mem_wren),
    .o_cpu_hold(o_cpu_hold), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  logic [7:0]        progBytes [0:1023];
  logic [ADDR_W-1:0] expAddr [$];
  logic [31:0]       expData [$];
  logic [ADDR_W-1:0] popAddr;
  logic [31:0]       popData;
  bit backToBack = 1'b0;
  int loadStartCyc = 0, lastWrenCyc = 0, doneCyc = 0;
  int wrenInLoad = 0, wrenSeen = 0, errSeen = 0, doneSeen = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Every write must match the next word the program bytes call for
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_mem_wren) begin
        wrenSeen++;
        if (expAddr.size() == 0) begin
          checkOutput("unexpected wren", 32'(o_mem_wren), 32'd0);
        end else begin
          popAddr = expAddr.pop_front();
          popData = expData.pop_front();
          checkOutput("write address", 32'(o_mem_address), 32'(popAddr));
          checkOutput("write data", o_mem_data, popData);
        end
        checkOutput("hold/busy/ready during write", 32'({o_cpu_hold, o_busy, o_byte_ready}), 32'd6);
        if (backToBack) begin
          if (wrenInLoad == 0) checkOutput("first write latency", cyc - loadStartCyc, 4);
          else checkOutput("word period", cyc - lastWrenCyc, 5);
        end
        wrenInLoad++;
        lastWrenCyc = cyc;
      end
      if (o_error) errSeen++;
      if (o_done) begin
        doneSeen++;
        doneCyc = cyc;
        checkOutput("done releases hold", 32'({o_cpu_hold, o_busy}), 32'd0);
      end
    end
  end

  task automatic randomizeProgram();
    for (int i = 0; i < 1024; i++) progBytes[i] = 8'($urandom);
  endtask

  task automatic applyStimulus(input int nwords, input bit stall, input bit pokeStart, input int abortAfter);
    int nbytes, idx, guard, doneBase, wrBase, errBase;
    bit v, rdy, poked;
    logic [31:0] lastWord;
    nbytes = (abortAfter > 0) ? abortAfter : nwords * 4;
    lastWord = '0;
    for (int w = 0; w < nbytes / 4; w++) begin
      lastWord = {progBytes[4*w+3], progBytes[4*w+2], progBytes[4*w+1], progBytes[4*w]};
      expAddr.push_back(ADDR_W'(w));
      expData.push_back(lastWord);
    end
    doneBase = doneSeen;
    wrBase = wrenSeen;
    errBase = errSeen;
    backToBack = !stall;
    wrenInLoad = 0;
    @(negedge i_clk);
    i_start = 1'b1;
    i_num_words = (ADDR_W+1)'(nwords);
    i_byte_valid = !stall;
    i_byte_data = progBytes[0];
    @(negedge i_clk);
    i_start = 1'b0;
    loadStartCyc = cyc;
    #1;
    checkOutput("hold after start", 32'(o_cpu_hold), 32'd1);
    checkOutput("busy after start", 32'(o_busy), 32'd1);
    idx = 0;
    guard = 0;
    poked = 1'b0;
    while (idx < nbytes && guard < nbytes * 20 + 50) begin
      rdy = o_byte_ready;
      v = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      i_byte_valid = v;
      i_byte_data = progBytes[idx];
      if (pokeStart && !poked && idx == 5) begin
        i_start = 1'b1;
        i_num_words = (ADDR_W+1)'(1);
        poked = 1'b1;
      end
      @(posedge i_clk);
      if (v && rdy) idx++;
      @(negedge i_clk);
      i_start = 1'b0;
      guard++;
    end
    i_byte_valid = 1'b0;
    checkOutput("bytes accepted", idx, nbytes);
    if (abortAfter > 0) begin
      i_rst = 1'b1;
      @(posedge i_clk);
      @(negedge i_clk);
      #1;
      checkOutput("abort flags", 32'({o_byte_ready, o_mem_wren, o_cpu_hold, o_busy, o_done, o_error}), 32'd0);
      checkOutput("abort address", 32'(o_mem_address), 32'd0);
      checkOutput("abort data", o_mem_data, 32'd0);
      i_rst = 1'b0;
      i_byte_valid = 1'b1;
      repeat (10) begin
        @(negedge i_clk);
        i_byte_data = 8'($urandom);
      end
      i_byte_valid = 1'b0;
      #1;
      checkOutput("writes before abort only", wrenSeen - wrBase, nbytes / 4);
      checkOutput("idle after abort", 32'({o_byte_ready, o_busy, o_cpu_hold}), 32'd0);
    end else begin
      guard = 0;
      while (doneSeen == doneBase && guard < 20) begin
        @(negedge i_clk);
        #1;
        guard++;
      end
      checkOutput("done seen", doneSeen - doneBase, 1);
      checkOutput("done after last write", doneCyc - lastWrenCyc, 1);
      @(negedge i_clk);
      #1;
      checkOutput("done width", 32'(o_done), 32'd0);
      checkOutput("idle hold/busy/ready", 32'({o_cpu_hold, o_busy, o_byte_ready}), 32'd0);
      checkOutput("single done", doneSeen - doneBase, 1);
      checkOutput("write count", wrenSeen - wrBase, nwords);
      checkOutput("pending writes", expAddr.size(), 0);
      checkOutput("address held", 32'(o_mem_address), nwords - 1);
      checkOutput("data held", o_mem_data, lastWord);
    end
    checkOutput("no error during load", errSeen - errBase, 0);
  endtask

  task automatic applyReject(input int n);
    int errBase, wrBase;
    errBase = errSeen;
    wrBase = wrenSeen;
    @(negedge i_clk);
    i_start = 1'b1;
    i_num_words = (ADDR_W+1)'(n);
    @(negedge i_clk);
    i_start = 1'b0;
    #1;
    checkOutput("reject error pulse", 32'(o_error), 32'd1);
    checkOutput("reject stays idle", 32'({o_busy, o_cpu_hold, o_byte_ready}), 32'd0);
    @(negedge i_clk);
    #1;
    checkOutput("reject error width", 32'(o_error), 32'd0);
    checkOutput("reject error count", errSeen - errBase, 1);
    checkOutput("reject no write", wrenSeen - wrBase, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge i_clk);
    #1;
    checkOutput("reset flags", 32'({o_byte_ready, o_mem_wren, o_cpu_hold, o_busy, o_done, o_error}), 32'd0);
    checkOutput("reset address", 32'(o_mem_address), 32'd0);
    checkOutput("reset data", o_mem_data, 32'd0);
    i_rst = 1'b0;

    progBytes[0] = 8'h13; progBytes[1] = 8'h05; progBytes[2] = 8'hA0; progBytes[3] = 8'h00;
    applyStimulus(1, 1'b0, 1'b0, 0);
    checkOutput("known first word", o_mem_data, 32'h00A00513);

    randomizeProgram();
    applyStimulus(3, 1'b0, 1'b0, 0);

    randomizeProgram();
    applyStimulus(2, 1'b0, 1'b0, 0);
    applyStimulus(2, 1'b1, 1'b0, 0);

    applyReject(0);
    applyReject(DEPTH + 1);
    randomizeProgram();
    applyStimulus(DEPTH, 1'b0, 1'b0, 0);

    randomizeProgram();
    applyStimulus(4, 1'b0, 1'b0, 6);
    randomizeProgram();
    applyStimulus(1, 1'b0, 1'b0, 0);

    randomizeProgram();
    applyStimulus(3, 1'b0, 1'b1, 0);
    randomizeProgram();
    applyStimulus(3, 1'b1, 1'b1, 0);

    repeat (4) begin
      randomizeProgram();
      applyStimulus($urandom_range(1, 6), $urandom_range(0, 1) == 1, 1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
